// File: rtl/bpsk_demod_pkg.sv
// Shared BPSK definitions: sample/product widths, clog2 helper, FSM states
// and the stage-1 pipeline record. The TX mixer bench uses the same package.
package bpsk_pkg;

    localparam int SAMPLE_W = 8;
    localparam int PROD_W   = 16;

    typedef enum logic {
        IDLE      = 1'b0,
        INTEGRATE = 1'b1
    } state_t;

    // Registered multiplier output with its framing flags
    typedef struct packed {
        logic              vld;
        logic              first;
        logic              last;
        logic [PROD_W-1:0] prod;
    } s1_t;

    // Ceiling log2; constant-folded at elaboration
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/bpsk_demod_integrate_dump.sv
// Integrate-and-dump accumulator. A first-flagged product restarts the sum,
// a last-flagged product produces the decision and clears the accumulator.
// `BPSK_DEMOD_SOFT_EN adds the held soft-decision output.
module integrate_dump import bpsk_pkg::*; #(
    parameter int ACC_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     vld,
    input  logic                     first,
    input  logic                     last,
    input  logic signed [PROD_W-1:0] prod,
    output logic                     done,
    output logic                     dec_bit
`ifdef BPSK_DEMOD_SOFT_EN
    ,
    output logic signed [ACC_W-1:0]  soft_out
`endif
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic                    dump;

    assign dump = vld && last;

    // Running sum including the product currently in stage 1
    always_comb begin
        base = first ? '0 : acc;
        sum  = base + ACC_W'(prod);
    end

    // Accumulator; a drop of demod_ena discards the partial bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              acc <= '0;
        else if (clr || dump) acc <= '0;
        else if (vld)         acc <= sum;
    end

    // Decision strobe and sliced bit; a zero sum decides 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            dec_bit <= 1'b0;
        end else begin
            done <= dump;
            if (dump) dec_bit <= ~sum[ACC_W-1];
        end
    end

`ifdef BPSK_DEMOD_SOFT_EN
    // Soft decision held until the next bit completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       soft_out <= '0;
        else if (dump) soft_out <= sum;
    end
`endif

endmodule

// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: multiply by local carrier, integrate over one
// bit period, slice the sign. Two-cycle latency from the last sample.
// Optional soft output under `BPSK_DEMOD_SOFT_EN.
module bpsk_demod import bpsk_pkg::*; #(
    parameter  int SAMPLES_PER_BIT = 16,
    parameter  int ACC_W           = 20,
    localparam int CNT_W           = clog2(SAMPLES_PER_BIT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       demod_ena,
    input  logic                       bit_sync,
    input  logic signed [SAMPLE_W-1:0] rx_sample,
    input  logic signed [SAMPLE_W-1:0] sine,
    output logic                       ena_demod,
    output logic                       data_out,
    output logic                       data_valid,
    output logic [CNT_W-1:0]           sample_cnt
`ifdef BPSK_DEMOD_SOFT_EN
    ,
    output logic signed [ACC_W-1:0]    soft_out
`endif
);

    if (SAMPLES_PER_BIT < 2 || SAMPLES_PER_BIT > 256) begin : g_bad_spb
        $error("bpsk_demod: SAMPLES_PER_BIT must be in 2..256");
    end
    if (ACC_W < PROD_W + CNT_W) begin : g_bad_acc
        $error("bpsk_demod: ACC_W too small for SAMPLES_PER_BIT");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_BIT - 1);

    state_t                    state_q, state_d;
    s1_t                       s1_q;
    logic                      first_d, last_d;
    logic signed [PROD_W-1:0]  prod_d;

    assign prod_d = PROD_W'(rx_sample) * PROD_W'(sine);

    // Next state and stage-1 framing flags
    always_comb begin
        state_d = state_q;
        first_d = (state_q == IDLE) || (sample_cnt == '0) || bit_sync;
        last_d  = (sample_cnt == LAST_IDX) && !bit_sync;
        case (state_q)
            IDLE:      if (demod_ena)  state_d = INTEGRATE;
            INTEGRATE: if (!demod_ena) state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Sample index: bit_sync makes this sample index 0, idle clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        sample_cnt <= '0;
        else if (!demod_ena)            sample_cnt <= '0;
        else if (bit_sync)              sample_cnt <= CNT_W'(1);
        else if (sample_cnt == LAST_IDX) sample_cnt <= '0;
        else                            sample_cnt <= sample_cnt + 1'b1;
    end

    // Stage 1: product register with valid/first/last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else if (demod_ena) begin
            s1_q.vld   <= 1'b1;
            s1_q.first <= first_d;
            s1_q.last  <= last_d;
            s1_q.prod  <= prod_d;
        end else begin
            s1_q.vld <= 1'b0;
        end
    end

    // Enable echo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ena_demod <= 1'b0;
        else     ena_demod <= demod_ena;
    end

    integrate_dump #(.ACC_W(ACC_W)) u_int_dump (
        .clk     (clk),
        .rst     (rst),
        .clr     (!demod_ena),
        .vld     (s1_q.vld),
        .first   (s1_q.first),
        .last    (s1_q.last),
        .prod    (s1_q.prod),
        .done    (data_valid),
        .dec_bit (data_out)
`ifdef BPSK_DEMOD_SOFT_EN
        ,
        .soft_out(soft_out)
`endif
    );

endmodule

// File: tb/tb_bpsk_demod.sv
// Self-checking bench for bpsk_demod with a bit-level reference model.
module tb_bpsk_demod;
    localparam int SPB = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              demod_ena = 1'b0;
    logic              bit_sync = 1'b0;
    logic signed [7:0] rx_sample = '0;
    logic signed [7:0] sine = '0;
    logic              ena_demod, data_out, data_valid;
    logic [3:0]        sample_cnt;
`ifdef BPSK_DEMOD_SOFT_EN
    logic signed [19:0] soft_out;
`endif

    bpsk_demod #(.SAMPLES_PER_BIT(SPB), .ACC_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .demod_ena  (demod_ena),
        .bit_sync   (bit_sync),
        .rx_sample  (rx_sample),
        .sine       (sine),
        .ena_demod  (ena_demod),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sample_cnt (sample_cnt)
`ifdef BPSK_DEMOD_SOFT_EN
        ,
        .soft_out   (soft_out)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    // reference model: bit framing with expected outputs after the coming edge
    int m_idx = 0, m_run = 0, m_pend_sum = 0;
    bit m_pend = 1'b0;
    bit exp_valid = 1'b0, exp_data = 1'b0, exp_ena = 1'b0;
    int exp_cnt = 0, exp_soft = 0;

    int      nstrobe = 0;
    bit [31:0] bits_seen = '0;
    bit      burst = 1'b0;
    bit      prev_in_burst = 1'b0;
    longint  last_t = 0;

    int sine_tab [4] = '{0, 127, 0, -127};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_run = 0; m_pend = 0; m_pend_sum = 0;
        exp_valid = 0; exp_data = 0; exp_ena = 0; exp_cnt = 0; exp_soft = 0;
    endtask

    // One accepted/idle cycle: a bit completes SPB accepted samples after its start
    task automatic model_edge(input bit en, input bit sy, input int p);
        exp_ena   = en;
        exp_valid = m_pend;
        if (m_pend) begin
            exp_data = (m_pend_sum >= 0);
            exp_soft = m_pend_sum;
        end
        m_pend = 0;
        if (en) begin
            if (sy || m_idx == 0) begin
                m_run = 0;
                m_idx = 0;
            end
            m_run += p;
            m_idx++;
            if (m_idx == SPB) begin
                m_pend     = 1;
                m_pend_sum = m_run;
                m_idx      = 0;
            end
        end else begin
            m_idx = 0;
            m_run = 0;
        end
        exp_cnt = m_idx;
    endtask

    task automatic step(input bit en, input bit sy, input int rx, input int sn);
        @(negedge clk);
        demod_ena = en;
        bit_sync  = sy;
        rx_sample = 8'(rx);
        sine      = 8'(sn);
        model_edge(en, sy, rx * sn);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic send_bit(input bit b, input bit sy);
        for (int i = 0; i < SPB; i++)
            step(1, sy && (i == 0), b ? sine_tab[i % 4] : -sine_tab[i % 4], sine_tab[i % 4]);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // compare DUT against the model every cycle outside reset
    always begin
        @(posedge clk);
        #2;
        if (!rst && run_cmp) begin
            chk("data_valid", data_valid, exp_valid);
            chk("data_out", data_out, exp_data);
            chk("ena_demod", ena_demod, exp_ena);
            chk("sample_cnt", sample_cnt, exp_cnt);
`ifdef BPSK_DEMOD_SOFT_EN
            chk("soft_out", soft_out, exp_soft);
`endif
            if (data_valid) begin
                nstrobe++;
                bits_seen = {bits_seen[30:0], data_out};
                if (burst && prev_in_burst) chk("burst_gap", $time - last_t, 160);
                prev_in_burst = burst;
                last_t = $time;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        #1 rst = 1'b1;
        #3;
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ena", ena_demod, 0);
        chk("rst_cnt", sample_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_cmp = 1'b1;

        // bit 1: rx = sine
        idle(2);
        send_bit(1, 0);
        idle(1);
        after_edge();
        chk("t1_valid", data_valid, 1);
        chk("t1_bit", data_out, 1);
        chk("t1_model_sum", exp_soft, 129032);
`ifdef BPSK_DEMOD_SOFT_EN
        chk("t1_soft", soft_out, 129032);
`endif

        // bit 0: rx = -sine
        idle(1);
        send_bit(0, 0);
        idle(1);
        after_edge();
        chk("t2_valid", data_valid, 1);
        chk("t2_bit", data_out, 0);
        chk("t2_model_sum", exp_soft, -129032);
`ifdef BPSK_DEMOD_SOFT_EN
        chk("t2_soft", soft_out, -129032);
`endif

        // 8 alternating bits back-to-back
        idle(2);
        n0 = nstrobe;
        burst = 1'b1;
        for (int i = 0; i < 8; i++) send_bit((i % 2) == 0, 0);
        idle(2);
        burst = 1'b0;
        chk("t3_strobes", nstrobe - n0, 8);
        chk("t3_pattern", bits_seen[7:0], 8'b10101010);

        // all-zero samples: tie decides 1
        for (int i = 0; i < SPB; i++) step(1, 0, 0, sine_tab[i % 4]);
        idle(1);
        after_edge();
        chk("t4_valid", data_valid, 1);
        chk("t4_bit", data_out, 1);
        chk("t4_model_sum", exp_soft, 0);
`ifdef BPSK_DEMOD_SOFT_EN
        chk("t4_soft", soft_out, 0);
`endif

        // demod_ena dropped after sample 10
        idle(2);
        n0 = nstrobe;
        for (int i = 0; i < 10; i++) step(1, 0, sine_tab[i % 4], sine_tab[i % 4]);
        step(0, 0, 0, 0);
        #1;
        chk("t5_ena_lag_hi", ena_demod, 1);
        after_edge();
        chk("t5_ena_lag_lo", ena_demod, 0);
        chk("t5_cnt_clr", sample_cnt, 0);
        idle(3);
        chk("t5_no_strobe", nstrobe - n0, 0);
        send_bit(1, 0);
        idle(1);
        after_edge();
        chk("t5_valid", data_valid, 1);
        chk("t5_bit", data_out, 1);
        idle(1);
        chk("t5_strobes", nstrobe - n0, 1);

        // bit_sync on sample 5 restarts the window
        idle(2);
        n0 = nstrobe;
        for (int i = 0; i < 5; i++) step(1, 0, sine_tab[i % 4], sine_tab[i % 4]);
        send_bit(0, 1);
        idle(1);
        after_edge();
        chk("t6_valid", data_valid, 1);
        chk("t6_bit", data_out, 0);
        idle(1);
        chk("t6_strobes", nstrobe - n0, 1);

        // async reset mid-integration
        send_bit(1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, sine_tab[i % 4], sine_tab[i % 4]);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_rst_valid", data_valid, 0);
        chk("t7_rst_data", data_out, 0);
        chk("t7_rst_ena", ena_demod, 0);
        chk("t7_rst_cnt", sample_cnt, 0);
`ifdef BPSK_DEMOD_SOFT_EN
        chk("t7_rst_soft", soft_out, 0);
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        demod_ena = 1'b0;
        bit_sync  = 1'b0;
        rx_sample = '0;
        sine      = '0;
        rst       = 1'b0;
        send_bit(0, 0);
        idle(1);
        after_edge();
        chk("t7_valid", data_valid, 1);
        chk("t7_bit", data_out, 0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
